// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO between CPU UART stores and the async transmitter.
// Define UART_TX_DROP_CNT_EN to add o_drop_cnt, a saturating rejected-store count.
module uart_tx_buffer #(
  parameter  int DEPTH       = 16,
  parameter  int ACK_TIMEOUT = 4,
  parameter  int WORD_W      = 32,
  localparam int AW          = $clog2(DEPTH),
  localparam int CW          = AW + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_start,
  input  logic [WORD_W-1:0] i_cpu_t_data,
  output logic              o_cpu_busy,
  output logic              o_tx_start,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_busy,
`ifdef UART_TX_DROP_CNT_EN
  output logic [15:0]       o_drop_cnt,
`endif
  output logic [CW-1:0]     o_fifo_count
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [7:0]      r_tx_data;
  logic [TW-1:0]   r_tmo;
  logic            w_pop;
  logic            w_push;
  logic            w_full;
  logic            w_tmo_clr;
  logic            w_tmo_inc;
  logic            w_unused;

  assign w_unused = ^i_cpu_t_data[WORD_W-1:8];

  assign w_full = (r_count == CW'(DEPTH));
  // a full FIFO still accepts a store on the cycle it pops
  assign w_push = i_cpu_start && (!w_full || w_pop);

  assign o_cpu_busy   = w_full;
  assign o_tx_start   = (r_state == S_LAUNCH);
  assign o_tx_data    = r_tx_data;
  assign o_fifo_count = r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt     = r_state;
    w_pop     = 1'b0;
    w_tmo_clr = 1'b0;
    w_tmo_inc = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_count != '0 && !i_tx_busy) begin
          w_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_pop     = 1'b1;
        w_tmo_clr = 1'b1;
        w_nxt     = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (i_tx_busy) begin
          w_nxt = S_WAIT_DONE;
        end else if (r_tmo == TW'(ACK_TIMEOUT - 1)) begin
          w_nxt = S_IDLE;
        end else begin
          w_tmo_inc = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!i_tx_busy) begin
          w_nxt = S_IDLE;
        end
      end
      default: begin
        w_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_tx_data <= 8'h00;
      r_tmo     <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_tx_data <= r_mem[r_rd_ptr];
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (w_tmo_clr) begin
        r_tmo <= '0;
      end else if (w_tmo_inc) begin
        r_tmo <= r_tmo + TW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_push) begin
      r_mem[r_wr_ptr] <= i_cpu_t_data[7:0];
    end
  end

`ifdef UART_TX_DROP_CNT_EN
  logic [15:0] r_drop;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_drop <= 16'h0000;
    end else if (i_cpu_start && !w_push && r_drop != 16'hFFFF) begin
      r_drop <= r_drop + 16'd1;
    end
  end

  assign o_drop_cnt = r_drop;
`else
  // rejected stores simply vanish
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: directed + random stimulus, queue scoreboard
// driven by a transaction-level FIFO model of the buffer.
module tb_uart_tx_buffer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_start;
  logic [31:0] cpu_t_data;
  logic        tx_busy = 1'b0;
  logic        cpu_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [4:0]  fifo_count;
`ifdef UART_TX_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  uart_tx_buffer #(.DEPTH(DEPTH), .ACK_TIMEOUT(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cpu_start  (cpu_start),
    .i_cpu_t_data (cpu_t_data),
    .o_cpu_busy   (cpu_busy),
    .o_tx_start   (tx_start),
    .o_tx_data    (tx_data),
    .i_tx_busy    (tx_busy),
`ifdef UART_TX_DROP_CNT_EN
    .o_drop_cnt   (drop_cnt),
`endif
    .o_fifo_count (fifo_count)
  );

  int         checks = 0;
  int         failures = 0;
  logic [7:0] sb_q [$];
  logic [7:0] exp_txd = 8'h00;
  int         mdrop = 0;
  int         cyc = 0;
  int         start_cnt = 0;
  int         last_start_cyc = -100;
  int         last_gap = 0;
  int         fpp_cnt = 0;
  logic       prev_busy = 1'b0;
  bit         m_full;
  int         txmode = 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard/monitor: pops the expected byte on every launch,
  // pushes accepted stores, compares every visible output.
  always @(negedge clk) begin
    cyc++;
    chk("fifo_count", fifo_count, sb_q.size());
    chk("cpu_busy", cpu_busy, sb_q.size() == DEPTH);
    chk("tx_data", tx_data, exp_txd);
`ifdef UART_TX_DROP_CNT_EN
    chk("drop_cnt", drop_cnt, mdrop);
`endif
    if (!rst_n) begin
      sb_q.delete();
      exp_txd = 8'h00;
      mdrop = 0;
      last_start_cyc = -100;
    end else begin
      m_full = (sb_q.size() == DEPTH);
      if (tx_start) begin
        start_cnt++;
        chk("launch_after_busy", prev_busy, 1'b0);
        if (last_start_cyc >= 0) begin
          last_gap = cyc - last_start_cyc;
          chk("start_gap_min", last_gap >= 4, 1'b1);
        end
        last_start_cyc = cyc;
        if (sb_q.size() == 0) begin
          chk("tx_start_nonempty", 32'd0, 32'd1);
        end else begin
          exp_txd = sb_q.pop_front();
        end
      end
      if (cpu_start) begin
        if (!m_full || tx_start) begin
          sb_q.push_back(cpu_t_data[7:0]);
          if (m_full) fpp_cnt++;
        end else if (mdrop < 65535) begin
          mdrop++;
        end
      end
    end
    prev_busy = tx_busy;
  end

  // Transmitter model: 0 ack next cycle for 10 cycles, 1 never acks,
  // 2 stuck busy, 3 random ack/length/glitches.
  initial begin
    bit s;
    int left;
    left = 0;
    forever begin
      @(negedge clk);
      s = tx_start;
      @(posedge clk);
      #2;
      case (txmode)
        0: begin
          if (s) left = 10;
          else if (left > 0) left--;
          tx_busy = (left > 0);
        end
        1: begin
          left = 0;
          tx_busy = 1'b0;
        end
        2: begin
          left = 0;
          tx_busy = 1'b1;
        end
        default: begin
          if (s) left = ($urandom_range(3) == 0) ? 0 : $urandom_range(8, 1);
          else if (left > 0) left--;
          tx_busy = (left > 0) || ($urandom_range(15) == 0);
        end
      endcase
    end
  end

  task automatic push(input logic [7:0] b);
    cpu_start = 1'b1;
    cpu_t_data = {$urandom_range(32'hFF_FFFF), b};
    tick(1);
    cpu_start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk("drain_in_budget", n < budget, 1'b1);
    tick(20);
  endtask

  initial begin
    int s0;
    int pc;
    int n;
    rst_n = 1'b0;
    cpu_start = 1'b1;
    cpu_t_data = 32'h0000_00EE;
    tick(2);
    rst_n = 1'b1;
    cpu_start = 1'b0;
    chk("rst_count", fifo_count, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_cpu_busy", cpu_busy, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    tick(3);

    // single byte, launch latency
    txmode = 0;
    tick(1);
    s0 = start_cnt;
    pc = cyc + 1;
    cpu_start = 1'b1;
    cpu_t_data = 32'h0000_0041;
    tick(1);
    cpu_start = 1'b0;
    n = 0;
    while (start_cnt == s0 && n < 20) begin
      tick(1);
      n++;
    end
    chk("launch_latency", last_start_cyc - pc, 2);
    wait_drain(100);
    chk("single_tx_data", tx_data, 8'h41);
    chk("single_count", fifo_count, 0);

    // fill while transmitter busy, overflow, then pop+push when full
    txmode = 2;
    tick(2);
    for (int i = 0; i < DEPTH; i++) push(i[7:0]);
    chk("fill_cpu_busy", cpu_busy, 1);
    chk("fill_count", fifo_count, 16);
    push(8'h10);
    chk("ovf_count", fifo_count, 16);
`ifdef UART_TX_DROP_CNT_EN
    chk("ovf_drop", drop_cnt, 1);
`endif
    txmode = 0;
    tick(1);
    push(8'hAA);
    chk("full_pop_push_count", fifo_count, 16);
    chk("full_pop_push_seen", fpp_cnt, 1);
    wait_drain(400);
    chk("drained_last", tx_data, 8'hAA);
    chk("ack_gap", last_gap, 13);

    // ack timeout
    txmode = 1;
    tick(1);
    for (int i = 0; i < 3; i++) push(8'h30 + i[7:0]);
    wait_drain(100);
    chk("timeout_gap", last_gap, 6);

    // pointer wrap
    for (int i = 0; i < 40; i++) begin
      push($urandom_range(255));
      tick(3);
    end
    wait_drain(400);

    // reset in WAIT_DONE with bytes queued
    txmode = 0;
    tick(1);
    for (int i = 0; i < 6; i++) push(8'h50 + i[7:0]);
    chk("midxfer_count", fifo_count, 5);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("midxfer_rst_count", fifo_count, 0);
    s0 = start_cnt;
    tick(30);
    chk("midxfer_no_start", start_cnt, s0);

    // random traffic
    txmode = 3;
    for (int i = 0; i < 3000; i++) begin
      cpu_start = ($urandom_range(99) < 45);
      cpu_t_data = $urandom;
      rst_n = ($urandom_range(599) != 0);
      tick(1);
    end
    cpu_start = 1'b0;
    rst_n = 1'b1;
    wait_drain(3000);
    txmode = 0;
    tick(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
